// File: rtl/present_dec_key_sched.sv
// PRESENT decryption key schedule: rolls the master key forward to the last round,
// then streams round keys K32..K1 by undoing one update per handshake.
module present_dec_key_sched #(
  parameter int KEY_W      = 80,
  parameter int NUM_ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [63:0]      rk_data,
  output logic [5:0]       rk_idx,
  output logic             rk_last,
  output logic             done
);

  if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
    $error("present_dec_key_sched: KEY_W must be 80 or 128");
  end

  // Round-counter injection point differs between the two key sizes.
  localparam int          XP       = (KEY_W == 128) ? 62 : 15;
  localparam logic [5:0]  LAST_IDX = 6'(NUM_ROUNDS + 1);
  localparam logic [5:0]  CNT_END  = 6'(NUM_ROUNDS);
  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {IDLE, FWD, OUT} state_e;

  function automatic logic [KEY_W-1:0] fwd_upd(input logic [KEY_W-1:0] k, input logic [4:0] c);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = SBOX[r[KEY_W-1 -: 4]*4 +: 4];
    if (KEY_W == 128) r[KEY_W-5 -: 4] = SBOX[r[KEY_W-5 -: 4]*4 +: 4];
    r[XP +: 5] = r[XP +: 5] ^ c;
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] inv_upd(input logic [KEY_W-1:0] k, input logic [4:0] j);
    logic [KEY_W-1:0] r;
    r = k;
    r[XP +: 5] = r[XP +: 5] ^ j;
    r[KEY_W-1 -: 4] = SBOX_INV[r[KEY_W-1 -: 4]*4 +: 4];
    if (KEY_W == 128) r[KEY_W-5 -: 4] = SBOX_INV[r[KEY_W-5 -: 4]*4 +: 4];
    return {r[60:0], r[KEY_W-1:61]};
  endfunction

  state_e           state_q;
  logic [KEY_W-1:0] key_q, key_d;
  logic [5:0]       cnt_q, rk_idx_q;
  logic             busy_q, rk_valid_q, done_q;

  // idx[4:0]-1 mod 32 equals (idx-1)[4:0], including idx=32.
  always_comb begin
    key_d = key_q;
    case (state_q)
      IDLE: if (start) key_d = key_in;
      FWD:  key_d = fwd_upd(key_q, cnt_q[4:0]);
      OUT:  if (rk_ready && rk_idx_q > 6'd1) key_d = inv_upd(key_q, rk_idx_q[4:0] - 5'd1);
      default: key_d = key_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      cnt_q      <= '0;
      rk_idx_q   <= '0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      key_q  <= key_d;
      case (state_q)
        IDLE: if (start) begin
          cnt_q   <= 6'd1;
          busy_q  <= 1'b1;
          state_q <= FWD;
        end
        FWD: begin
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == CNT_END) begin
            state_q    <= OUT;
            rk_idx_q   <= LAST_IDX;
            rk_valid_q <= 1'b1;
          end
        end
        OUT: if (rk_ready) begin
          if (rk_idx_q > 6'd1) begin
            rk_idx_q <= rk_idx_q - 6'd1;
          end else begin
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_data  = key_q[KEY_W-1 -: 64];
  assign rk_idx   = rk_idx_q;
  assign rk_last  = rk_valid_q && (rk_idx_q == 6'd1);
  assign done     = done_q;

endmodule

// File: tb/tb_present_dec_key_sched.sv
// Scoreboarded bench for present_dec_key_sched: an 80-bit and a 128-bit instance
// checked against an independent forward key-schedule model and PRESENT decryption.
module tb_present_dec_key_sched;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start80 = 0, ready80 = 0, busy80, valid80, last80, done80;
  logic [79:0] key80 = '0;
  logic [63:0] data80;
  logic [5:0]  idx80;
  logic         start128 = 0, ready128 = 0, busy128, valid128, last128, done128;
  logic [127:0] key128 = '0;
  logic [63:0]  data128;
  logic [5:0]   idx128;

  present_dec_key_sched #(.KEY_W(80), .NUM_ROUNDS(31)) dut80 (
    .clk(clk), .rst_n(rst_n), .start(start80), .key_in(key80), .busy(busy80),
    .rk_valid(valid80), .rk_ready(ready80), .rk_data(data80), .rk_idx(idx80),
    .rk_last(last80), .done(done80));

  present_dec_key_sched #(.KEY_W(128), .NUM_ROUNDS(31)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(start128), .key_in(key128), .busy(busy128),
    .rk_valid(valid128), .rk_ready(ready128), .rk_data(data128), .rk_idx(idx128),
    .rk_last(last128), .done(done128));

  typedef struct packed {logic [63:0] d; logic [5:0] idx;} exp_t;
  exp_t q80[$], q128[$];
  exp_t e80, e128;
  int checks = 0, failures = 0, hs80 = 0, hs128 = 0;
  logic [63:0] cap80 [1:32];
  logic [63:0] cap128 [1:32];
  logic [3:0] SB  [16] = '{4'hC,4'h5,4'h6,4'hB,4'h9,4'h0,4'hA,4'hD,4'h3,4'hE,4'hF,4'h8,4'h4,4'h7,4'h1,4'h2};
  logic [3:0] SBI [16] = '{4'h5,4'hE,4'hF,4'h8,4'hC,4'h1,4'h2,4'hD,4'hB,4'h4,4'h6,4'h3,4'h0,4'h7,4'h9,4'hA};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Forward model: K1 is the master key's top 64 bits, K(i+1) from update with counter i.
  task automatic push_exp(input logic [127:0] key, input bit wide);
    logic [63:0]  rk [1:32];
    logic [79:0]  a;
    logic [127:0] b;
    a = key[79:0];
    b = key;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = wide ? b[127:64] : a[79:16];
      a = {a[18:0], a[79:19]};
      a[79:76] = SB[a[79:76]];
      a[19:15] = a[19:15] ^ 5'(i);
      b = {b[66:0], b[127:67]};
      b[127:124] = SB[b[127:124]];
      b[123:120] = SB[b[123:120]];
      b[66:62] = b[66:62] ^ 5'(i);
    end
    for (int i = 32; i >= 1; i--) begin
      if (wide) q128.push_back('{d: rk[i], idx: 6'(i)});
      else      q80.push_back('{d: rk[i], idx: 6'(i)});
    end
  endtask

  function automatic logic [63:0] dec80(input logic [63:0] ct);
    logic [63:0] s, t;
    s = ct ^ cap80[32];
    for (int r = 31; r >= 1; r--) begin
      for (int i = 0; i < 63; i++) t[i] = s[(i * 16) % 63];
      t[63] = s[63];
      for (int n = 0; n < 16; n++) t[n*4 +: 4] = SBI[t[n*4 +: 4]];
      s = t ^ cap80[r];
    end
    return s;
  endfunction

  logic stall80 = 0, stall128 = 0;
  logic [63:0] hd80, hd128;
  logic [5:0]  hi80, hi128;

  always @(negedge clk) begin
    if (!rst_n) stall80 = 0;
    else begin
      if (stall80) begin
        chk("hold_data80", data80, hd80);
        chk("hold_idx80", idx80, hi80);
      end
      if (valid80 && ready80) begin
        hs80++;
        if (idx80 >= 1 && idx80 <= 32) cap80[idx80] = data80;
        if (q80.size() == 0) chk("sb_unexpected80", valid80, 0);
        else begin
          e80 = q80.pop_front();
          chk("rk_data80", data80, e80.d);
          chk("rk_idx80", idx80, e80.idx);
          chk("rk_last80", last80, e80.idx == 6'd1);
        end
      end
      stall80 = valid80 && !ready80;
      hd80 = data80;
      hi80 = idx80;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) stall128 = 0;
    else begin
      if (stall128) begin
        chk("hold_data128", data128, hd128);
        chk("hold_idx128", idx128, hi128);
      end
      if (valid128 && ready128) begin
        hs128++;
        if (idx128 >= 1 && idx128 <= 32) cap128[idx128] = data128;
        if (q128.size() == 0) chk("sb_unexpected128", valid128, 0);
        else begin
          e128 = q128.pop_front();
          chk("rk_data128", data128, e128.d);
          chk("rk_idx128", idx128, e128.idx);
          chk("rk_last128", last128, e128.idx == 6'd1);
        end
      end
      stall128 = valid128 && !ready128;
      hd128 = data128;
      hi128 = idx128;
    end
  end

  task automatic wait_done80(output int n, input bit rnd);
    n = 0;
    while (!done80 && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (rnd) ready80 = 1'($urandom_range(0, 1));
    end
    chk("done80_seen", done80, 1);
  endtask

  task automatic pulse_start80();
    @(posedge clk); #1 start80 = 1;
    @(posedge clk); #1 start80 = 0;
  endtask

  int n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy80", busy80, 0);
    chk("rst_valid80", valid80, 0);
    chk("rst_data80", data80, 0);
    chk("rst_idx80", idx80, 0);
    chk("rst_done80", done80, 0);
    chk("rst_valid128", valid128, 0);
    chk("rst_data128", data128, 0);
    rst_n = 1;

    // Zero key, ready tied high: latency, back-to-back stream, known vector.
    ready80 = 1; key80 = '0; hs80 = 0;
    push_exp(128'd0, 0);
    pulse_start80();
    chk("t1_busy", busy80, 1);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      chk("t1_no_valid_yet", valid80, 0);
    end
    @(posedge clk); #1;
    chk("t1_valid_rise", valid80, 1);
    chk("t1_first_idx", idx80, 32);
    wait_done80(n, 0);
    chk("t1_stream_cycles", n, 32);
    chk("t1_busy_at_done", busy80, 0);
    chk("t1_k2", cap80[2], 64'hC000000000000000);
    chk("t1_k1", cap80[1], 64'h0);
    chk("t1_hs", hs80, 32);
    chk("t1_decrypt", dec80(64'h5579C1387B228445), 64'h0);
    @(posedge clk); #1;
    chk("t1_done_pulse", done80, 0);

    // All-ones key with random back-pressure.
    ready80 = 0; key80 = '1; hs80 = 0;
    push_exp({48'd0, {80{1'b1}}}, 0);
    pulse_start80();
    wait_done80(n, 1);
    chk("t2_hs", hs80, 32);
    chk("t2_k1", cap80[1], 64'hFFFFFFFFFFFFFFFF);
    chk("t2_sb_empty", q80.size(), 0);

    // 128-bit keys, random keys and stalls.
    for (int k = 0; k < 3; k++) begin
      key128 = {$urandom, $urandom, $urandom, $urandom};
      hs128 = 0;
      push_exp(key128, 1);
      @(posedge clk); #1 start128 = 1;
      @(posedge clk); #1 start128 = 0;
      n = 0;
      while (!done128 && n < 1000) begin
        @(posedge clk); #1;
        n++;
        ready128 = 1'($urandom_range(0, 1));
      end
      chk("t3_done128", done128, 1);
      chk("t3_hs128", hs128, 32);
      chk("t3_k1_128", cap128[1], key128[127:64]);
      chk("t3_sb_empty128", q128.size(), 0);
    end

    // Asynchronous reset in mid-stream, then a clean restart.
    ready80 = 1; key80 = {16'($urandom), $urandom, $urandom};
    push_exp({48'd0, key80}, 0);
    pulse_start80();
    n = 0;
    while (idx80 != 6'd17 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_reached17", idx80, 17);
    rst_n = 0;
    #1;
    chk("t4_rst_busy", busy80, 0);
    chk("t4_rst_valid", valid80, 0);
    chk("t4_rst_data", data80, 0);
    chk("t4_rst_idx", idx80, 0);
    chk("t4_rst_last", last80, 0);
    chk("t4_rst_done", done80, 0);
    q80.delete();
    @(posedge clk); #1 rst_n = 1;
    hs80 = 0;
    push_exp({48'd0, key80}, 0);
    pulse_start80();
    wait_done80(n, 0);
    chk("t4_hs_after", hs80, 32);

    // start held high: one load per sequence, reload on the done cycle.
    key80 = {16'($urandom), $urandom, $urandom};
    hs80 = 0;
    push_exp({48'd0, key80}, 0);
    push_exp({48'd0, key80}, 0);
    @(posedge clk); #1 start80 = 1;
    wait_done80(n, 0);
    chk("t5_busy_done1", busy80, 0);
    @(posedge clk); #1;
    chk("t5_reload_busy", busy80, 1);
    chk("t5_done_low", done80, 0);
    wait_done80(n, 0);
    start80 = 0;
    @(posedge clk); #1;
    chk("t5_idle_after", busy80, 0);
    chk("t5_hs", hs80, 64);
    chk("t5_sb_empty", q80.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/present_dec_key_sched.md
Name: present_dec_key_sched

Overview:
Decryption-side key schedule for the PRESENT datapath. It is the inverse counterpart of the encryption key scheduler. The block takes the master key, rolls it forward to the final-round register state, and then streams round keys in reverse order, K32 down to K1, over a valid/ready interface. The round-key state is rebuilt each step with the inverse update, so no 32-entry key array is stored. It feeds the decryption round engine.

Parameters:
KEY_W, 80, key register width; only 80 and 128 are legal. Any other value is an elaboration error.
NUM_ROUNDS, 31, number of key-update steps; the block emits NUM_ROUNDS+1 round keys.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  load request; sampled only while busy=0.
key_in  input  KEY_W  master key; captured on the cycle start is accepted.
busy  output  1  high from the edge that accepts start until the edge that emits done.
rk_valid  output  1  rk_data and rk_idx are valid.
rk_ready  input  1  consumer accepts the current round key.
rk_data  output  64  round key, equal to K[KEY_W-1:KEY_W-64].
rk_idx  output  6  round number of rk_data, from 32 down to 1.
rk_last  output  1  equals rk_valid && rk_idx==1.
done  output  1  one-cycle pulse after the K1 handshake.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - Key register, counter, rk_idx, rk_data, busy, rk_valid and done are all 0.
  - Any operation in progress is abandoned with no partial output.
- States: IDLE -> FWD -> OUT -> IDLE.
- IDLE:
  - start=1 at an edge: K<=key_in, cnt<=1, busy<=1, state goes to FWD.
- FWD, one update per cycle for cnt = 1..NUM_ROUNDS:
  - KEY_W=80: K <<< 61; then K[79:76] = S(K[79:76]); then K[19:15] ^= cnt[4:0].
  - KEY_W=128: K <<< 61; then S on K[127:124] and on K[123:120]; then K[66:62] ^= cnt[4:0].
  - S = {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2}, indexed 0..F.
  - On the update with cnt==NUM_ROUNDS: state goes to OUT, rk_idx<=32, rk_valid<=1.
  - Latency: rk_valid rises exactly 31 edges after the start-accept edge.
- OUT:
  - rk_data and rk_idx are held stable while rk_valid && !rk_ready.
  - On a handshake with rk_idx>1: apply the inverse update with j=rk_idx-1, then rk_idx<=rk_idx-1. rk_valid stays 1, giving one key per cycle under continuous ready.
    - KEY_W=80: K[19:15] ^= j; then K[79:76] = Sinv(K[79:76]); then K >>> 61.
    - KEY_W=128: K[66:62] ^= j; then Sinv on both top nibbles; then K >>> 61.
  - Sinv = {5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A}.
  - On a handshake with rk_idx==1: rk_valid<=0, busy<=0, done<=1 for one cycle, state goes to IDLE.
- start while busy=1 is ignored, with no effect on state or outputs.
- start in the same cycle as the done pulse is accepted, since busy is already 0.
- rk_ready asserted outside OUT has no effect.
- rk_ready may be tied high.
- All arithmetic is XOR or rotation. There is no carry and nothing wraps. cnt is 6 bits, but only [4:0] enters the XOR.

Test Plan:
- KEY_W=80, key_in=0, rk_ready=1 -> 31 cycles after start, rk_valid=1 with rk_idx=32. Sequence: 32 keys in 32 consecutive cycles, all matching the golden forward model in reverse. rk_idx=2 gives rk_data=0xC000000000000000. rk_idx=1 gives rk_data=0 together with rk_last=1. done pulses the next cycle, then busy=0.
- KEY_W=80, key_in=all ones, random rk_ready stalls -> rk_data/rk_idx never change while not handshaken. The K1 beat gives rk_data=0xFFFFFFFFFFFFFFFF. Exactly 32 handshakes occur.
- Integration: feed the keys to the decryption round engine with ciphertext 0x5579C1387B228445 and a zero key -> plaintext 0x0000000000000000.
- KEY_W=128, random keys vs golden model -> reversed sequence matches. Final K1 = key_in[127:64].
- rst_n pulsed low at rk_idx=17 -> all outputs 0 immediately. A new start then yields a full 32-key sequence.
- start held high throughout -> exactly one load per sequence. Reload happens on the done cycle with zero idle gap.
